score_counter: RTL and testbench

//   Game score keeper. Turns gameplay event pulses (hit, bonus, miss) into a saturating
//   0..999 binary score and a life count. Controls the IDLE/PLAY/OVER game flow.

---
 rtl/score_pkg.sv | 39 +++
 rtl/score_counter_edge_detect.sv | 24 ++
 rtl/score_counter.sv | 157 +++++++++++++++
 tb/tb_score_counter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types and constants for the score_counter block.
// Holds field widths, FSM state encodings, the per-cycle event bundle
// and the saturating score adder used by the top level.
package score_pkg;

  localparam int SCORE_W = 10;
  localparam int LIVES_W = 2;
  // Sum width: one extra bit so score + increment never wraps before the clamp.
  localparam int SUM_W   = SCORE_W + 1;

  // FSM encodings; the unused code 2'd3 is steered back to S_IDLE.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_OVER = 2'd2;

  // Rising-edge events seen in the current cycle.
  typedef struct packed {
    logic start;
    logic hit;
    logic bonus;
    logic miss;
  } evt_t;

  // Add an increment to the score and clamp at the ceiling.
  function automatic logic [SCORE_W-1:0] sat_add(
    input logic [SCORE_W-1:0] cur,
    input logic [SUM_W-1:0]   inc,
    input logic [SUM_W-1:0]   ceil
  );
    logic [SUM_W-1:0] sum;
    sum = {1'b0, cur} + inc;
    if (sum > ceil) begin
      sat_add = ceil[SCORE_W-1:0];
    end else begin
      sat_add = sum[SCORE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/score_counter_edge_detect.sv
// Rising-edge detector for one level input in the pclk domain.
// rise_o is combinational so an edge arriving in cycle n is acted on
// at the pclk edge that closes cycle n; a level held high fires once.
module edge_detect (
  input  logic pclk,
  input  logic rst_n,
  input  logic in_i,
  output logic rise_o
);

  logic in_q;

  // One-cycle delayed copy of the input.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      in_q <= 1'b0;
    end else begin
      in_q <= in_i;
    end
  end

  assign rise_o = in_i & ~in_q;

endmodule

// File: rtl/score_counter.sv
// Game score keeper: converts hit/bonus/miss pulses into a saturating
// score and a life count, and sequences IDLE -> PLAY -> OVER -> PLAY.
// Optional feature macro: HIGH_SCORE_EN builds a best-score register
// updated at game end; without it high_score is tied to zero.
module score_counter
  import score_pkg::*;
#(
  parameter int SCORE_MAX  = 999,
  parameter int HIT_PTS    = 1,
  parameter int BONUS_PTS  = 10,
  parameter int LIVES_INIT = 3
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        hit,
  input  logic        bonus,
  input  logic        miss,
  output logic [9:0]  score,
  output logic [1:0]  lives,
  output logic        playing,
  output logic        game_over,
  output logic        score_upd,
  output logic [9:0]  high_score
);

  localparam logic [SUM_W-1:0]   CEIL_C      = SUM_W'(SCORE_MAX);
  localparam logic [SUM_W-1:0]   HIT_C       = SUM_W'(HIT_PTS);
  localparam logic [SUM_W-1:0]   BONUS_C     = SUM_W'(BONUS_PTS);
  localparam logic [LIVES_W-1:0] LIVES_INIT_C = LIVES_W'(LIVES_INIT);

  evt_t ev_s;

  logic [1:0]         state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic               playing_q, playing_d;
  logic               over_q, over_d;
  logic               upd_q, upd_d;
  logic [SUM_W-1:0]   inc_s;

  edge_detect u_ed_start (.pclk(pclk), .rst_n(rst_n), .in_i(start), .rise_o(ev_s.start));
  edge_detect u_ed_hit   (.pclk(pclk), .rst_n(rst_n), .in_i(hit),   .rise_o(ev_s.hit));
  edge_detect u_ed_bonus (.pclk(pclk), .rst_n(rst_n), .in_i(bonus), .rise_o(ev_s.bonus));
  edge_detect u_ed_miss  (.pclk(pclk), .rst_n(rst_n), .in_i(miss),  .rise_o(ev_s.miss));

  // Points earned this cycle; hit and bonus together both count.
  always_comb begin
    inc_s = {SUM_W{1'b0}};
    if (ev_s.hit) begin
      inc_s = inc_s + HIT_C;
    end else begin
      inc_s = inc_s;
    end
    if (ev_s.bonus) begin
      inc_s = inc_s + BONUS_C;
    end else begin
      inc_s = inc_s;
    end
  end

  // Game FSM with score and lives next-state logic.
  always_comb begin
    state_d = state_q;
    score_d = score_q;
    lives_d = lives_q;
    case (state_q)
      S_IDLE, S_OVER: begin
        // Gameplay events are ignored; score stays on display until a new game.
        if (ev_s.start) begin
          state_d = S_PLAY;
          score_d = {SCORE_W{1'b0}};
          lives_d = LIVES_INIT_C;
        end else begin
          state_d = state_q;
        end
      end
      S_PLAY: begin
        // Points land even in the cycle of the final miss; start is ignored.
        score_d = sat_add(score_q, inc_s, CEIL_C);
        if (ev_s.miss) begin
          if (lives_q <= 2'd1) begin
            lives_d = 2'd0;
            state_d = S_OVER;
          end else begin
            lives_d = lives_q - 2'd1;
          end
        end else begin
          lives_d = lives_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status flags are derived from the next state so they line up with it.
  always_comb begin
    playing_d = (state_d == S_PLAY);
    over_d    = (state_d == S_OVER);
    upd_d     = (score_d != score_q);
  end

  // Main state and output registers.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      score_q   <= {SCORE_W{1'b0}};
      lives_q   <= {LIVES_W{1'b0}};
      playing_q <= 1'b0;
      over_q    <= 1'b0;
      upd_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      score_q   <= score_d;
      lives_q   <= lives_d;
      playing_q <= playing_d;
      over_q    <= over_d;
      upd_q     <= upd_d;
    end
  end

  assign score     = score_q;
  assign lives     = lives_q;
  assign playing   = playing_q;
  assign game_over = over_q;
  assign score_upd = upd_q;

`ifdef HIGH_SCORE_EN
  logic [SCORE_W-1:0] high_q, high_d;

  // Capture the final score (including same-cycle points) when a game ends.
  always_comb begin
    high_d = high_q;
    if ((state_q == S_PLAY) && (state_d == S_OVER) && (score_d > high_q)) begin
      high_d = score_d;
    end else begin
      high_d = high_q;
    end
  end

  // Best-score register; survives restarts, cleared only by reset.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      high_q <= {SCORE_W{1'b0}};
    end else begin
      high_q <= high_d;
    end
  end

  assign high_score = high_q;
`else
  assign high_score = 10'd0;
`endif

endmodule

// File: tb/tb_score_counter.sv
// Self-checking bench for score_counter. Expected output vectors
// {score, lives, playing, game_over} are queued as stimulus is driven
// and popped when the DUT result is sampled.
module tb_score_counter;

  logic       pclk = 1'b0;
  logic       rst_n;
  logic       start, hit, bonus, miss;
  logic [9:0] score;
  logic [1:0] lives;
  logic       playing, game_over, score_upd;
  logic [9:0] high_score;

  int checks   = 0;
  int failures = 0;
  int upd_cnt  = 0;
  int base;

  logic [13:0] sb_q[$];
  logic [13:0] exp_v, obs_v;
  logic [9:0]  exp_high;

  score_counter dut (
    .pclk(pclk), .rst_n(rst_n), .start(start), .hit(hit), .bonus(bonus), .miss(miss),
    .score(score), .lives(lives), .playing(playing), .game_over(game_over),
    .score_upd(score_upd), .high_score(high_score)
  );

  always #5 pclk = ~pclk;

  // Count score_upd pulses mid-cycle, away from the active edge.
  always @(negedge pclk) begin
    if (score_upd === 1'b1) upd_cnt++;
  end

  task automatic cyc(input logic s, input logic h, input logic b, input logic m);
    start = s; hit = h; bonus = b; miss = m;
    @(posedge pclk); #1;
  endtask

  task automatic pulse(input logic s, input logic h, input logic b, input logic m);
    cyc(s, h, b, m);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0; hit = 1'b0; bonus = 1'b0; miss = 1'b0;
    @(posedge pclk); @(posedge pclk); #1;
    sb_q.push_back({10'd0, 2'd0, 1'b0, 1'b0});
    obs_v = {score, lives, playing, game_over}; exp_v = sb_q.pop_front(); checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL reset_state got=%h exp=%h", obs_v, exp_v); end
    checks++;
    if (score_upd !== 1'b0 || high_score !== 10'd0) begin
      failures++; $display("FAIL reset_upd_high got upd=%b high=%0d exp 0 0", score_upd, high_score);
    end
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    // gameplay events in IDLE must be ignored
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    sb_q.push_back({10'd0, 2'd0, 1'b0, 1'b0});
    obs_v = {score, lives, playing, game_over}; exp_v = sb_q.pop_front(); checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL idle_ignore got=%h exp=%h", obs_v, exp_v); end
  endtask

  task automatic test_start_hold();
    base = upd_cnt;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    sb_q.push_back({10'd0, 2'd3, 1'b1, 1'b0});
    obs_v = {score, lives, playing, game_over}; exp_v = sb_q.pop_front(); checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL start_play got=%h exp=%h", obs_v, exp_v); end
    checks++;
    if (upd_cnt - base !== 0) begin failures++; $display("FAIL start_no_upd got=%0d exp=0", upd_cnt - base); end
    base = upd_cnt;
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    sb_q.push_back({10'd1, 2'd3, 1'b1, 1'b0});
    obs_v = {score, lives, playing, game_over}; exp_v = sb_q.pop_front(); checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL hit_hold got=%h exp=%h", obs_v, exp_v); end
    checks++;
    if (upd_cnt - base !== 1) begin failures++; $display("FAIL hit_hold_upd got=%0d exp=1", upd_cnt - base); end
  endtask

  task automatic test_points();
    base = upd_cnt;
    for (int i = 0; i < 5; i++) pulse(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) pulse(1'b0, 1'b0, 1'b1, 1'b0);
    sb_q.push_back({10'd26, 2'd3, 1'b1, 1'b0});
    obs_v = {score, lives, playing, game_over}; exp_v = sb_q.pop_front(); checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL points got=%h exp=%h", obs_v, exp_v); end
    checks++;
    if (upd_cnt - base !== 7) begin failures++; $display("FAIL points_upd got=%0d exp=7", upd_cnt - base); end
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    sb_q.push_back({10'd37, 2'd3, 1'b1, 1'b0});
    obs_v = {score, lives, playing, game_over}; exp_v = sb_q.pop_front(); checks++;
    if (obs_v !== exp_v || score_upd !== 1'b1) begin
      failures++; $display("FAIL hit_bonus_same got=%h upd=%b exp=%h upd=1", obs_v, score_upd, exp_v);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    // start during play is ignored
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    sb_q.push_back({10'd37, 2'd3, 1'b1, 1'b0});
    obs_v = {score, lives, playing, game_over}; exp_v = sb_q.pop_front(); checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL start_in_play got=%h exp=%h", obs_v, exp_v); end
    for (int i = 0; i < 3; i++) pulse(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_miss();
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    sb_q.push_back({10'd40, 2'd2, 1'b1, 1'b0});
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    sb_q.push_back({10'd40, 2'd1, 1'b1, 1'b0});
    obs_v = {score, lives, playing, game_over}; exp_v = sb_q.pop_back(); checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL miss_two got=%h exp=%h", obs_v, exp_v); end
    sb_q.delete();
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    sb_q.push_back({10'd40, 2'd0, 1'b0, 1'b1});
    obs_v = {score, lives, playing, game_over}; exp_v = sb_q.pop_front(); checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL game_over got=%h exp=%h", obs_v, exp_v); end
`ifdef HIGH_SCORE_EN
    exp_high = 10'd40;
`else
    exp_high = 10'd0;
`endif
    checks++;
    if (high_score !== exp_high) begin failures++; $display("FAIL high_first got=%0d exp=%0d", high_score, exp_high); end
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    sb_q.push_back({10'd40, 2'd0, 1'b0, 1'b1});
    obs_v = {score, lives, playing, game_over}; exp_v = sb_q.pop_front(); checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL over_ignore got=%h exp=%h", obs_v, exp_v); end
  endtask

  task automatic test_high();
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    sb_q.push_back({10'd0, 2'd3, 1'b1, 1'b0});
    obs_v = {score, lives, playing, game_over}; exp_v = sb_q.pop_front(); checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL restart got=%h exp=%h", obs_v, exp_v); end
    base = upd_cnt;
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b1, 1'b0, 1'b1);
    sb_q.push_back({10'd12, 2'd0, 1'b0, 1'b1});
    obs_v = {score, lives, playing, game_over}; exp_v = sb_q.pop_front(); checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL final_miss_pts got=%h exp=%h", obs_v, exp_v); end
    checks++;
    if (upd_cnt - base !== 3) begin failures++; $display("FAIL game2_upd got=%0d exp=3", upd_cnt - base); end
    checks++;
    if (high_score !== exp_high) begin failures++; $display("FAIL high_kept got=%0d exp=%0d", high_score, exp_high); end
  endtask

  task automatic test_async_reset();
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) pulse(1'b0, 1'b0, 1'b1, 1'b0);
    sb_q.push_back({10'd300, 2'd3, 1'b1, 1'b0});
    obs_v = {score, lives, playing, game_over}; exp_v = sb_q.pop_front(); checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL score_300 got=%h exp=%h", obs_v, exp_v); end
    rst_n = 1'b0;
    #2;
    sb_q.push_back({10'd0, 2'd0, 1'b0, 1'b0});
    obs_v = {score, lives, playing, game_over}; exp_v = sb_q.pop_front(); checks++;
    if (obs_v !== exp_v || high_score !== 10'd0) begin
      failures++; $display("FAIL async_reset got=%h high=%0d exp=%h high=0", obs_v, high_score, exp_v);
    end
    @(negedge pclk);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_saturate();
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 99; i++) pulse(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) pulse(1'b0, 1'b1, 1'b0, 1'b0);
    sb_q.push_back({10'd995, 2'd3, 1'b1, 1'b0});
    obs_v = {score, lives, playing, game_over}; exp_v = sb_q.pop_front(); checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL score_995 got=%h exp=%h", obs_v, exp_v); end
    base = upd_cnt;
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    sb_q.push_back({10'd999, 2'd3, 1'b1, 1'b0});
    obs_v = {score, lives, playing, game_over}; exp_v = sb_q.pop_front(); checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL sat_bonus got=%h exp=%h", obs_v, exp_v); end
    checks++;
    if (upd_cnt - base !== 1) begin failures++; $display("FAIL sat_bonus_upd got=%0d exp=1", upd_cnt - base); end
    base = upd_cnt;
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b1, 1'b0);
    sb_q.push_back({10'd999, 2'd3, 1'b1, 1'b0});
    obs_v = {score, lives, playing, game_over}; exp_v = sb_q.pop_front(); checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL sat_hold got=%h exp=%h", obs_v, exp_v); end
    checks++;
    if (upd_cnt - base !== 0) begin failures++; $display("FAIL sat_hold_upd got=%0d exp=0", upd_cnt - base); end
  endtask

  initial begin
    test_reset();
    test_start_hold();
    test_points();
    test_miss();
    test_high();
    test_async_reset();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
